// File: rtl/nist_verdict_tally.sv
// ============================================================================
//  nist_verdict_tally
//  Tallies approximate-entropy verdicts: counts, windows, consecutive-fail alarm.
//  Optional macro VERDICT_HISTORY_EN adds an 8-verdict history port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module nist_verdict_tally #(
   parameter int WINDOW     = 16,
   parameter int FAIL_LIMIT = 3,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       valid_in,
   input  logic       is_random_in,
   input  logic       clear,
   input  logic [1:0] sel,
   output logic [7:0] status_out,
   output logic       alarm,
`ifdef VERDICT_HISTORY_EN
   output logic [7:0] history_out,
`endif
   output logic       window_done
);

   localparam logic [1:0]       ST_IDLE    = 2'd0;
   localparam logic [1:0]       ST_MONITOR = 2'd1;
   localparam logic [1:0]       ST_ALARM   = 2'd2;
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [7:0]       WIN_LAST   = 8'(WINDOW - 1);
   localparam logic [3:0]       FAIL_TGT   = 4'(FAIL_LIMIT);

   logic             valid_d;
   logic [CNT_W-1:0] total;
   logic [CNT_W-1:0] pass;
   logic [7:0]       win_cnt;
   logic [7:0]       win_pass;
   logic [7:0]       last_win_pass;
   logic [3:0]       consec_fail;
   logic [1:0]       state;
   logic [1:0]       state_next;

   logic       ev;
   logic [3:0] cf_inc;
   logic [7:0] win_pass_next;
   logic       fail_hit;

   assign ev            = valid_in & ~valid_d;
   assign cf_inc        = (consec_fail == 4'hF) ? 4'hF : consec_fail + 4'd1;
   assign win_pass_next = win_pass + {7'd0, is_random_in};
   assign fail_hit      = ev & ~is_random_in & (cf_inc == FAIL_TGT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_d       <= 1'b0;
         total         <= '0;
         pass          <= '0;
         win_cnt       <= '0;
         win_pass      <= '0;
         last_win_pass <= '0;
         consec_fail   <= '0;
         window_done   <= 1'b0;
      end else begin
         // valid_d tracks valid_in even during clear so a held level is not recounted
         valid_d     <= valid_in;
         window_done <= 1'b0;
         if (clear) begin
            total         <= '0;
            pass          <= '0;
            win_cnt       <= '0;
            win_pass      <= '0;
            last_win_pass <= '0;
            consec_fail   <= '0;
         end else if (ev) begin
            if (total != CNT_MAX)
               total <= total + CNT_ONE;
            if (is_random_in && (pass != CNT_MAX))
               pass <= pass + CNT_ONE;
            consec_fail <= is_random_in ? 4'd0 : cf_inc;
            if (win_cnt == WIN_LAST) begin
               last_win_pass <= win_pass_next;
               win_cnt       <= '0;
               win_pass      <= '0;
               window_done   <= 1'b1;
            end else begin
               win_cnt  <= win_cnt + 8'd1;
               win_pass <= win_pass_next;
            end
         end
      end
   end

`ifdef VERDICT_HISTORY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         history_out <= '0;
      else if (clear)
         history_out <= '0;
      else if (ev)
         history_out <= {history_out[6:0], is_random_in};
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (ev) state_next = fail_hit ? ST_ALARM : ST_MONITOR;
         ST_MONITOR: if (fail_hit) state_next = ST_ALARM;
         ST_ALARM:   state_next = ST_ALARM;
         default:    state_next = ST_IDLE;
      endcase
      if (clear)
         state_next = ST_IDLE;
   end

   // alarm follows the registered state, so it rises on the same edge as ALARM entry
   always_comb begin
      alarm = (state == ST_ALARM);
      case (sel)
         2'd0:    status_out = 8'(total);
         2'd1:    status_out = 8'(pass);
         2'd2:    status_out = last_win_pass;
         default: status_out = {alarm, state, 1'b0, consec_fail};
      endcase
   end

endmodule

`default_nettype wire
